alu_seq_issue: RTL and testbench
================================

Name: alu_seq_issue

Overview:
- Initiator side of the ALU operand/control interface.
- Accepts ALU commands over a valid/ready handshake and drives the 3-bit op code and both operands into the registered ALU.
- Waits the ALU's fixed pipeline latency, then captures the result and flags and presents them over a second valid/ready handshake.
- Sits between the datapath issue logic and the ALU, so upstream logic never tracks ALU timing. One command is outstanding at a time.

Parameters:
- WIDTH, 32, operand/result width in bits.
- LAT, 1, ALU latency in clock edges from operands presented to result valid; legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  000 ADD, 001 SUB, 010 AND, 011 XOR, 100 OR, 101-111 PASS (data1)
- cmd_a  in  WIDTH  operand 1
- cmd_b  in  WIDTH  operand 2
- alu_ctrl  out  3  op code to ALU
- alu_data1  out  WIDTH  operand 1 to ALU
- alu_data2  out  WIDTH  operand 2 to ALU
- alu_out  in  WIDTH  ALU result
- alu_carry  in  1  ALU carry/borrow
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  WIDTH  captured result
- res_carry  out  1  carry (ADD) / borrow (SUB); 0 for other ops
- res_zero  out  1  captured result == 0, all ops
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; cmd_ready=1; res_valid=0; res_data=0; res_carry=0; res_zero=0; alu_ctrl=3'b111; alu_data1=0; alu_data2=0; cycle counter=0.
- Reset has priority over every event. A command in flight is dropped and no result is produced.
- Reset is synchronous only: rst_n must not affect outputs between clock edges.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge A, register cmd_op, cmd_a and cmd_b, and go to EXEC.
- EXEC:
  - cmd_ready=0.
  - From cycle A+1, alu_ctrl/alu_data1/alu_data2 are driven from the registered command. They are held stable through capture.
  - Counter counts edges from 0. At the edge ending cycle A+LAT+1, capture the following and go to DONE:
    - alu_out into res_data.
    - res_carry = alu_carry if op is ADD or SUB, else 0.
    - res_zero computed locally as (alu_out == 0), not taken from the ALU.
- DONE:
  - res_valid=1 from cycle A+LAT+2. Command-to-res_valid latency is LAT+2 cycles.
  - alu_ctrl returns to 3'b111 and the operands return to 0.
  - res_* hold stable while res_valid=1 and res_ready=0, for unlimited backpressure.
  - On res_valid&res_ready, go to IDLE. res_valid=0 and cmd_ready=1 in the next cycle; res_data/res_carry/res_zero keep their last values.
  - No same-cycle result-retire/command-accept: back-to-back throughput is one op per LAT+3 cycles.
- cmd_valid while not ready is ignored. Upstream must hold the command until accepted.
- res_ready asserted with res_valid=0 has no effect.
- Arithmetic:
  - ADD carry is bit WIDTH of the WIDTH+1-bit sum.
  - SUB carry is bit WIDTH of a-b computed as a WIDTH+1-bit difference (1 = borrow, a<b unsigned).
  - The block does not recompute the ALU result; it trusts alu_out.

Optional Feature:
- Macro ALUSEQ_OVF_EN.
- Defined:
  - Adds output port res_ovf (1 bit, reset 0, captured with res_data).
  - ADD: res_ovf = (a[W-1]==b[W-1]) && (res_data[W-1]!=a[W-1]).
  - SUB: res_ovf = (a[W-1]!=b[W-1]) && (res_data[W-1]!=a[W-1]).
  - All other ops: 0.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Reset then idle: all outputs at reset values, cmd_ready=1, busy=0, alu_ctrl=3'b111.
- ADD a=32'hFFFFFFFF, b=1, LAT=1, res_ready=1: res_valid rises 3 cycles after accept with res_data=0, res_carry=1, res_zero=1; the next command is accepted in the cycle after retire.
- SUB cases:
  - a=5, b=5 -> res_data=0, res_zero=1, res_carry=0.
  - a=3, b=5 -> res_data=32'hFFFFFFFE, res_carry=1, res_zero=0.
- XOR a=32'hA5A5A5A5, b=32'hFFFF0000 -> res_data=32'h5A5AA5A5, res_carry=0 even with the ALU model forcing alu_carry=1; op 3'b110 a=7 -> res_data=7.
- Backpressure and command hold:
  - res_ready low for 10 cycles after res_valid: res_* stable, cmd_ready=0, and a held cmd_valid is not accepted until one cycle after retire.
  - With LAT=3, latency is 5 cycles.
- rst_n low for one edge during EXEC: next cycle is IDLE with res_valid=0 and no result ever presented for the dropped command.
- With ALUSEQ_OVF_EN:
  - ADD 32'h7FFFFFFF+1 -> res_ovf=1.
  - SUB 32'h80000000-1 -> res_ovf=1.
  - AND -> res_ovf=0.

Source files
------------

// File: rtl/alu_seq_issue.sv
// Issue sequencer for a registered ALU: accepts one command at a time, waits the ALU latency, returns result and flags.
// Optional macro ALUSEQ_OVF_EN adds the signed-overflow output res_ovf.
module alu_seq_issue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic             busy
`ifdef ALUSEQ_OVF_EN
  ,
  output logic             res_ovf
`endif
);

  localparam int unsigned CW      = 4;
  localparam logic [2:0]  OP_ADD  = 3'b000;
  localparam logic [2:0]  OP_SUB  = 3'b001;
  localparam logic [2:0]  OP_IDLE = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state,     w_state_nxt;
  logic [CW-1:0]    r_cnt,       w_cnt_nxt;
  logic [2:0]       r_alu_ctrl,  w_alu_ctrl_nxt;
  logic [WIDTH-1:0] r_alu_data1, w_alu_data1_nxt;
  logic [WIDTH-1:0] r_alu_data2, w_alu_data2_nxt;
  logic [WIDTH-1:0] r_res_data,  w_res_data_nxt;
  logic             r_res_carry, w_res_carry_nxt;
  logic             r_res_zero,  w_res_zero_nxt;
  logic             r_cmd_ready, r_res_valid, r_busy;
  logic             w_is_add, w_is_sub;
`ifdef ALUSEQ_OVF_EN
  logic             r_res_ovf,   w_res_ovf_nxt;
  logic             w_ovf;
`endif

  assign w_is_add = (r_alu_ctrl == OP_ADD);
  assign w_is_sub = (r_alu_ctrl == OP_SUB);

`ifdef ALUSEQ_OVF_EN
  // Signed overflow judged from operand signs still held on the ALU bus at capture.
  assign w_ovf = (w_is_add && (r_alu_data1[WIDTH-1] == r_alu_data2[WIDTH-1]) &&
                  (alu_out[WIDTH-1] != r_alu_data1[WIDTH-1])) ||
                 (w_is_sub && (r_alu_data1[WIDTH-1] != r_alu_data2[WIDTH-1]) &&
                  (alu_out[WIDTH-1] != r_alu_data1[WIDTH-1]));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_alu_ctrl  <= OP_IDLE;
      r_alu_data1 <= '0;
      r_alu_data2 <= '0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_zero  <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef ALUSEQ_OVF_EN
      r_res_ovf   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_alu_ctrl  <= w_alu_ctrl_nxt;
      r_alu_data1 <= w_alu_data1_nxt;
      r_alu_data2 <= w_alu_data2_nxt;
      r_res_data  <= w_res_data_nxt;
      r_res_carry <= w_res_carry_nxt;
      r_res_zero  <= w_res_zero_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_res_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
`ifdef ALUSEQ_OVF_EN
      r_res_ovf   <= w_res_ovf_nxt;
`endif
    end
  end

  // Counter runs from 0 on entry to EXEC; result is sampled when it reaches LAT.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_alu_ctrl_nxt  = r_alu_ctrl;
    w_alu_data1_nxt = r_alu_data1;
    w_alu_data2_nxt = r_alu_data2;
    w_res_data_nxt  = r_res_data;
    w_res_carry_nxt = r_res_carry;
    w_res_zero_nxt  = r_res_zero;
`ifdef ALUSEQ_OVF_EN
    w_res_ovf_nxt   = r_res_ovf;
`endif
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_state_nxt     = S_EXEC;
          w_cnt_nxt       = '0;
          w_alu_ctrl_nxt  = cmd_op;
          w_alu_data1_nxt = cmd_a;
          w_alu_data2_nxt = cmd_b;
        end
      end
      S_EXEC: begin
        if (r_cnt == CW'(LAT)) begin
          w_state_nxt     = S_DONE;
          w_res_data_nxt  = alu_out;
          w_res_carry_nxt = (w_is_add || w_is_sub) && alu_carry;
          w_res_zero_nxt  = (alu_out == '0);
`ifdef ALUSEQ_OVF_EN
          w_res_ovf_nxt   = w_ovf;
`endif
          w_alu_ctrl_nxt  = OP_IDLE;
          w_alu_data1_nxt = '0;
          w_alu_data2_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready = r_cmd_ready;
  assign res_valid = r_res_valid;
  assign busy      = r_busy;
  assign alu_ctrl  = r_alu_ctrl;
  assign alu_data1 = r_alu_data1;
  assign alu_data2 = r_alu_data2;
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_zero  = r_res_zero;
`ifdef ALUSEQ_OVF_EN
  assign res_ovf   = r_res_ovf;
`endif

endmodule

// File: tb/tb_alu_seq_issue.sv
// Directed bench for alu_seq_issue: LAT=1 instance for function/handshake, LAT=3 instance for latency.
module tb_alu_seq_issue;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         force_carry = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;

  logic         cmd_valid = 1'b0, cmd_valid3 = 1'b0;
  logic [2:0]   cmd_op = 3'b0;
  logic [W-1:0] cmd_a = '0, cmd_b = '0;
  logic         res_ready = 1'b0, res_ready3 = 1'b0;

  logic         cmd_ready, res_valid, res_carry, res_zero, busy, alu_carry;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_data1, alu_data2, alu_out, res_data;
  logic         cmd_ready3, res_valid3, res_carry3, res_zero3, busy3, alu_carry3;
  logic [2:0]   alu_ctrl3;
  logic [W-1:0] alu_data13, alu_data23, alu_out3, res_data3;
`ifdef ALUSEQ_OVF_EN
  logic         res_ovf, res_ovf3;
`endif

  always #5 clk = ~clk;

  alu_seq_issue #(.WIDTH(W), .LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_ctrl(alu_ctrl),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_out(alu_out),
    .alu_carry(alu_carry), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero), .busy(busy)
`ifdef ALUSEQ_OVF_EN
    , .res_ovf(res_ovf)
`endif
  );

  alu_seq_issue #(.WIDTH(W), .LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_ctrl(alu_ctrl3),
    .alu_data1(alu_data13), .alu_data2(alu_data23), .alu_out(alu_out3),
    .alu_carry(alu_carry3), .res_valid(res_valid3), .res_ready(res_ready3),
    .res_data(res_data3), .res_carry(res_carry3), .res_zero(res_zero3), .busy(busy3)
`ifdef ALUSEQ_OVF_EN
    , .res_ovf(res_ovf3)
`endif
  );

  // Reference ALU; force_carry drives a bogus carry on non-arithmetic ops.
  function automatic logic [W:0] alu_f(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    case (c)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {1'b0, a} - {1'b0, b};
      3'b010:  r = {1'b0, a & b};
      3'b011:  r = {1'b0, a ^ b};
      3'b100:  r = {1'b0, a | b};
      default: r = {1'b0, a};
    endcase
    if (force_carry && c != 3'b000 && c != 3'b001) r[W] = 1'b1;
    return r;
  endfunction

  logic [W:0] p1, q0, q1, q2;
  always @(posedge clk) begin
    p1 <= alu_f(alu_ctrl, alu_data1, alu_data2);
    q0 <= alu_f(alu_ctrl3, alu_data13, alu_data23);
    q1 <= q0;
    q2 <= q1;
  end
  assign alu_out    = p1[W-1:0];
  assign alu_carry  = p1[W];
  assign alu_out3   = q2[W-1:0];
  assign alu_carry3 = q2[W];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command to the LAT=1 instance and count cycles until res_valid.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic [2:0] c_seen,
                       output logic [W-1:0] a_seen, output logic [W-1:0] b_seen);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    c_seen = alu_ctrl; a_seen = alu_data1; b_seen = alu_data2;
    lat = 1;
    while (!res_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic retire();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({cmd_ready, busy, res_valid, res_carry, res_zero, alu_ctrl} !== 8'b1000_0111) begin
      n_err++;
      $display("FAIL reset_flags got %b want 10000111", {cmd_ready, busy, res_valid, res_carry, res_zero, alu_ctrl});
    end
    n_vec++;
    if ({res_data, alu_data1, alu_data2} !== '0) begin
      n_err++;
      $display("FAIL reset_data got %h/%h/%h want 0", res_data, alu_data1, alu_data2);
    end
    n_vec++;
    if ({cmd_ready3, busy3, res_valid3} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_lat3 got %b want 100", {cmd_ready3, busy3, res_valid3});
    end
  endtask

  task automatic test_add();
    int lat; logic [2:0] c; logic [W-1:0] a, b;
    issue(3'b000, 32'hFFFF_FFFF, 32'h1, lat, c, a, b);
    n_vec++;
    if (lat !== 3) begin n_err++; $display("FAIL add_latency got %0d want 3", lat); end
    n_vec++;
    if ({c, a, b} !== {3'b000, 32'hFFFF_FFFF, 32'h1}) begin
      n_err++; $display("FAIL add_alu_bus got %b %h %h want 000 ffffffff 00000001", c, a, b);
    end
    n_vec++;
    if ({res_data, res_carry, res_zero} !== {32'h0, 2'b11}) begin
      n_err++; $display("FAIL add_result got %h c%b z%b want 0 c1 z1", res_data, res_carry, res_zero);
    end
    n_vec++;
    if ({alu_ctrl, alu_data1, busy, cmd_ready} !== {3'b111, 32'h0, 2'b10}) begin
      n_err++; $display("FAIL add_done_state got %b %h b%b r%b want 111 0 b1 r0", alu_ctrl, alu_data1, busy, cmd_ready);
    end
    retire();
    n_vec++;
    if ({res_valid, cmd_ready, busy, res_data, res_carry, res_zero} !== {3'b010, 32'h0, 2'b11}) begin
      n_err++; $display("FAIL add_retire got v%b r%b b%b %h want v0 r1 b0 0 held", res_valid, cmd_ready, busy, res_data);
    end
  endtask

  task automatic test_sub();
    int lat; logic [2:0] c; logic [W-1:0] a, b;
    issue(3'b001, 32'd5, 32'd5, lat, c, a, b);
    n_vec++;
    if ({lat, res_data, res_carry, res_zero} !== {32'd3, 32'h0, 2'b01}) begin
      n_err++; $display("FAIL sub_eq got lat%0d %h c%b z%b want lat3 0 c0 z1", lat, res_data, res_carry, res_zero);
    end
    retire();
    issue(3'b001, 32'd3, 32'd5, lat, c, a, b);
    n_vec++;
    if ({res_data, res_carry, res_zero} !== {32'hFFFF_FFFE, 2'b10}) begin
      n_err++; $display("FAIL sub_borrow got %h c%b z%b want fffffffe c1 z0", res_data, res_carry, res_zero);
    end
    retire();
  endtask

  task automatic test_logic();
    int lat; logic [2:0] c; logic [W-1:0] a, b;
    force_carry = 1'b1;
    issue(3'b011, 32'hA5A5_A5A5, 32'hFFFF_0000, lat, c, a, b);
    n_vec++;
    if ({res_data, res_carry, res_zero} !== {32'h5A5A_A5A5, 2'b00}) begin
      n_err++; $display("FAIL xor got %h c%b z%b want 5a5aa5a5 c0 z0", res_data, res_carry, res_zero);
    end
    retire();
    issue(3'b110, 32'd7, 32'd9, lat, c, a, b);
    n_vec++;
    if ({res_data, res_carry, res_zero} !== {32'd7, 2'b00}) begin
      n_err++; $display("FAIL pass got %h c%b z%b want 00000007 c0 z0", res_data, res_carry, res_zero);
    end
    retire();
    issue(3'b010, 32'hF0F0_F0F0, 32'h0F0F_0F0F, lat, c, a, b);
    n_vec++;
    if ({res_data, res_carry, res_zero} !== {32'h0, 2'b01}) begin
      n_err++; $display("FAIL and got %h c%b z%b want 0 c0 z1", res_data, res_carry, res_zero);
    end
    retire();
    issue(3'b100, 32'h1234_0000, 32'h0000_5678, lat, c, a, b);
    n_vec++;
    if ({res_data, res_carry, res_zero} !== {32'h1234_5678, 2'b00}) begin
      n_err++; $display("FAIL or got %h c%b z%b want 12345678 c0 z0", res_data, res_carry, res_zero);
    end
    retire();
  endtask

  task automatic test_backpressure();
    int lat; logic [2:0] c; logic [W-1:0] a, b;
    bit bad;
    issue(3'b000, 32'd100, 32'd23, lat, c, a, b);
    cmd_op = 3'b100; cmd_a = 32'h0000_00F0; cmd_b = 32'h0000_000F; cmd_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ({res_valid, cmd_ready, res_data, res_carry, res_zero} !== {2'b10, 32'd123, 2'b00}) bad = 1'b1;
      tick();
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL bp_hold got v%b r%b %h want v1 r0 0000007b stable", res_valid, cmd_ready, res_data);
    end
    retire();
    n_vec++;
    if ({res_valid, cmd_ready, busy} !== 3'b010) begin
      n_err++; $display("FAIL bp_retire got v%b r%b b%b want v0 r1 b0", res_valid, cmd_ready, busy);
    end
    tick();
    cmd_valid = 1'b0;
    n_vec++;
    if ({busy, cmd_ready, alu_ctrl, alu_data1} !== {2'b10, 3'b100, 32'h0000_00F0}) begin
      n_err++; $display("FAIL bp_accept got b%b r%b %b %h want b1 r0 100 000000f0", busy, cmd_ready, alu_ctrl, alu_data1);
    end
    lat = 1;
    while (!res_valid && lat < 40) begin tick(); lat++; end
    n_vec++;
    if ({lat, res_data} !== {32'd3, 32'h0000_00FF}) begin
      n_err++; $display("FAIL bp_second got lat%0d %h want lat3 000000ff", lat, res_data);
    end
    retire();
  endtask

  task automatic test_lat3();
    int lat;
    bit bad;
    cmd_op = 3'b000; cmd_a = 32'd10; cmd_b = 32'd20; cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    lat = 1;
    bad = 1'b0;
    while (!res_valid3 && lat < 40) begin
      if (cmd_ready3 !== 1'b0 || alu_ctrl3 !== 3'b000 || alu_data23 !== 32'd20) bad = 1'b1;
      tick();
      lat++;
    end
    n_vec++;
    if (lat !== 5 || bad) begin
      n_err++; $display("FAIL lat3_latency got %0d bus_bad=%0d want 5 bus_bad=0", lat, bad);
    end
    n_vec++;
    if ({res_data3, res_carry3, res_zero3, busy3} !== {32'd30, 3'b001}) begin
      n_err++; $display("FAIL lat3_result got %h c%b z%b b%b want 0000001e c0 z0 b1", res_data3, res_carry3, res_zero3, busy3);
    end
    res_ready3 = 1'b1;
    tick();
    res_ready3 = 1'b0;
    n_vec++;
    if ({res_valid3, cmd_ready3} !== 2'b01) begin
      n_err++; $display("FAIL lat3_retire got v%b r%b want v0 r1", res_valid3, cmd_ready3);
    end
  endtask

  task automatic test_reset_exec();
    bit seen;
    cmd_op = 3'b000; cmd_a = 32'd1; cmd_b = 32'd2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({busy, cmd_ready, alu_ctrl} !== {2'b10, 3'b000}) begin
      n_err++; $display("FAIL rst_async got b%b r%b %b want b1 r0 000", busy, cmd_ready, alu_ctrl);
    end
    tick();
    rst_n = 1'b1;
    n_vec++;
    if ({busy, cmd_ready, res_valid, alu_ctrl} !== 6'b010_111) begin
      n_err++; $display("FAIL rst_exec got b%b r%b v%b %b want b0 r1 v0 111", busy, cmd_ready, res_valid, alu_ctrl);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid) seen = 1'b1;
      tick();
    end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL rst_dropped got res_valid=1 want never"); end
  endtask

`ifdef ALUSEQ_OVF_EN
  task automatic test_ovf();
    int lat; logic [2:0] c; logic [W-1:0] a, b;
    issue(3'b000, 32'h7FFF_FFFF, 32'h1, lat, c, a, b);
    n_vec++;
    if ({res_ovf, res_data, res_carry} !== {1'b1, 32'h8000_0000, 1'b0}) begin
      n_err++; $display("FAIL ovf_add got o%b %h c%b want o1 80000000 c0", res_ovf, res_data, res_carry);
    end
    retire();
    issue(3'b001, 32'h8000_0000, 32'h1, lat, c, a, b);
    n_vec++;
    if ({res_ovf, res_data, res_carry} !== {1'b1, 32'h7FFF_FFFF, 1'b0}) begin
      n_err++; $display("FAIL ovf_sub got o%b %h c%b want o1 7fffffff c0", res_ovf, res_data, res_carry);
    end
    retire();
    issue(3'b010, 32'h8000_0000, 32'h8000_0000, lat, c, a, b);
    n_vec++;
    if ({res_ovf, res_data} !== {1'b0, 32'h8000_0000}) begin
      n_err++; $display("FAIL ovf_and got o%b %h want o0 80000000", res_ovf, res_data);
    end
    retire();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_backpressure();
    test_lat3();
    test_reset_exec();
`ifdef ALUSEQ_OVF_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
